// File: rtl/zap_pkg.sv
// zap_pkg
// Shared definitions for the Zapper hit-test sequencer: the FSM state
// encoding, bit positions inside the CPU status word, the default target
// index width and a helper that clamps the requested target count.
package zap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_BLANK  = 3'd2,
        ST_TARGET = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int STAT_VALID   = 0;
    localparam int STAT_HIT     = 1;
    localparam int STAT_IDX_LO  = 2;
    localparam int STAT_IDX_HI  = 3;
    localparam int STAT_CHEAT   = 4;
    localparam int STAT_TIMEOUT = 5;
    localparam int STAT_BUSY    = 6;

    localparam int TGT_IDX_W = 2;

    // Requests for more targets than the hardware scans are reduced to the maximum.
    function automatic logic [2:0] clamp_count(input logic [2:0] cnt, input logic [2:0] max_cnt);
        return (cnt > max_cnt) ? max_cnt : cnt;
    endfunction

endpackage

// File: rtl/zap_frame_watchdog.sv
// zap_frame_watchdog
// Cycle counter that flags a stalled shot when no frame_start arrives in time.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   clear     - reload the count to 0 (frame_start, or sequencer not active)
//   enable    - count this cycle (sequencer in ARM/BLANK/TARGET)
//   time_up   - count has reached TIMEOUT_CYCLES-1 while enabled
module zap_frame_watchdog #(
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic time_up
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // The count saturates at LIMIT so it can never wrap back to an early value.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + CW'(1);
        end
    end

    assign time_up = enable && (count == LIMIT);

endmodule

// File: rtl/zap_frame_sequencer.sv
// zap_frame_sequencer
// Runs the light-gun hit test: on a trigger edge it requests BLANK_FRAMES
// all-black frames, then one white-target frame per active target, sampling
// the photodiode to find which target (if any) was hit.
// Ports:
//   clk, rst      - clock and synchronous active-high reset
//   frame_start   - one-cycle pulse at the start of each video frame
//   trigger       - synchronized trigger level (edge-detected here)
//   sensor        - synchronized light-sensor level, 1 = light seen
//   target_count  - number of active targets, sampled at the trigger edge
//   ack           - CPU pulse that clears result_valid
//   blank_req     - draw an all-black frame
//   target_req    - draw only target target_sel in white
//   target_sel    - target drawn while target_req=1
//   busy          - shot sequence in progress
//   status        - {9'b0, busy, timeout, cheat, idx[1:0], hit, valid}
module zap_frame_sequencer
    import zap_pkg::*;
#(
    parameter int MAX_TARGETS    = 4,
    parameter int BLANK_FRAMES   = 1,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_start,
    input  logic                 trigger,
    input  logic                 sensor,
    input  logic [2:0]           target_count,
    input  logic                 ack,
    output logic                 blank_req,
    output logic                 target_req,
    output logic [TGT_IDX_W-1:0] target_sel,
    output logic                 busy,
    output logic [15:0]          status
);

    state_t     state;
    logic       trig_prev;
    logic       trig_armed;
    logic [2:0] cnt_q;
    logic [2:0] idx_q;
    logic [1:0] blank_cnt;
    logic       hit_latch;
    logic       res_valid;
    logic       res_hit;
    logic [1:0] res_idx;
    logic       res_cheat;
    logic       res_timeout;

    logic       trig_edge;
    logic [2:0] count_clamped;
    logic [2:0] idx_next;
    logic [1:0] blank_next;
    logic       seen;
    logic       active;
    logic       time_up;

    // trig_armed only sets once trigger has been seen low, so a trigger held
    // high through reset release cannot fire a shot.
    assign trig_edge     = trigger && !trig_prev && trig_armed;
    assign count_clamped = clamp_count(target_count, 3'(MAX_TARGETS));
    assign idx_next      = idx_q + 3'd1;
    assign blank_next    = blank_cnt + 2'd1;
    // A sensor pulse coincident with frame_start still belongs to the ending frame.
    assign seen          = hit_latch || sensor;
    assign active        = (state == ST_ARM) || (state == ST_BLANK) || (state == ST_TARGET);

    zap_frame_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (frame_start || !active),
        .enable (active),
        .time_up(time_up)
    );

    // Sequencer FSM with registered draw requests and result fields; the
    // watchdog timeout overrides every other event in the active states.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            trig_prev   <= 1'b0;
            trig_armed  <= 1'b0;
            cnt_q       <= '0;
            idx_q       <= '0;
            blank_cnt   <= '0;
            hit_latch   <= 1'b0;
            blank_req   <= 1'b0;
            target_req  <= 1'b0;
            target_sel  <= '0;
            busy        <= 1'b0;
            res_valid   <= 1'b0;
            res_hit     <= 1'b0;
            res_idx     <= '0;
            res_cheat   <= 1'b0;
            res_timeout <= 1'b0;
        end else begin
            trig_prev <= trigger;
            if (!trigger) begin
                trig_armed <= 1'b1;
            end

            if (time_up) begin
                state       <= ST_DONE;
                blank_req   <= 1'b0;
                target_req  <= 1'b0;
                target_sel  <= '0;
                busy        <= 1'b0;
                res_valid   <= 1'b1;
                res_timeout <= 1'b1;
                res_hit     <= 1'b0;
                res_idx     <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (trig_edge) begin
                            res_hit     <= 1'b0;
                            res_idx     <= '0;
                            res_cheat   <= 1'b0;
                            res_timeout <= 1'b0;
                            if (count_clamped != 3'd0) begin
                                cnt_q <= count_clamped;
                                state <= ST_ARM;
                                busy  <= 1'b1;
                            end else begin
                                state     <= ST_DONE;
                                res_valid <= 1'b1;
                            end
                        end
                    end
                    ST_ARM: begin
                        if (frame_start) begin
                            state     <= ST_BLANK;
                            blank_cnt <= '0;
                            blank_req <= 1'b1;
                        end
                    end
                    ST_BLANK: begin
                        if (sensor) begin
                            state     <= ST_DONE;
                            blank_req <= 1'b0;
                            busy      <= 1'b0;
                            res_valid <= 1'b1;
                            res_cheat <= 1'b1;
                            res_hit   <= 1'b0;
                        end else if (frame_start) begin
                            blank_cnt <= blank_next;
                            if (blank_next == 2'(BLANK_FRAMES)) begin
                                state      <= ST_TARGET;
                                idx_q      <= '0;
                                hit_latch  <= 1'b0;
                                blank_req  <= 1'b0;
                                target_req <= 1'b1;
                                target_sel <= '0;
                            end
                        end
                    end
                    ST_TARGET: begin
                        if (frame_start) begin
                            if (seen || (idx_next == cnt_q)) begin
                                state      <= ST_DONE;
                                target_req <= 1'b0;
                                target_sel <= '0;
                                busy       <= 1'b0;
                                res_valid  <= 1'b1;
                                res_hit    <= seen;
                                res_idx    <= seen ? idx_q[1:0] : 2'd0;
                            end else begin
                                idx_q      <= idx_next;
                                target_sel <= idx_next[TGT_IDX_W-1:0];
                                hit_latch  <= 1'b0;
                            end
                        end else begin
                            hit_latch <= seen;
                        end
                    end
                    ST_DONE: begin
                        if (ack) begin
                            state     <= ST_IDLE;
                            res_valid <= 1'b0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // The status word is a direct view of registered result and busy bits.
    always_comb begin
        status                          = '0;
        status[STAT_VALID]              = res_valid;
        status[STAT_HIT]                = res_hit;
        status[STAT_IDX_HI:STAT_IDX_LO] = res_idx;
        status[STAT_CHEAT]              = res_cheat;
        status[STAT_TIMEOUT]            = res_timeout;
        status[STAT_BUSY]               = busy;
    end

endmodule

// File: tb/tb_zap_frame_sequencer.sv
// tb_zap_frame_sequencer
// Scoreboard bench: scenarios push the expected draw events and status words,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_zap_frame_sequencer;

    localparam int FL = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_start;
    logic       trigger;
    logic       sensor;
    logic [2:0] target_count;
    logic       ack;
    logic       blank_req;
    logic       target_req;
    logic [1:0] target_sel;
    logic       busy;
    logic [15:0] status;

    int total = 0;
    int bad   = 0;

    logic [7:0]  exp_draw[$];
    logic [15:0] exp_status[$];

    zap_frame_sequencer #(
        .MAX_TARGETS   (4),
        .BLANK_FRAMES  (1),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .trigger     (trigger),
        .sensor      (sensor),
        .target_count(target_count),
        .ack         (ack),
        .blank_req   (blank_req),
        .target_req  (target_req),
        .target_sel  (target_sel),
        .busy        (busy),
        .status      (status)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic popDraw(input logic [7:0] actual);
        if (exp_draw.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_draw actual=0x%0h required=none", actual);
        end else begin
            checkOutput("draw", 32'(actual), 32'(exp_draw.pop_front()));
        end
    endtask

    task automatic popStatus(input logic [15:0] actual);
        if (exp_status.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_status actual=0x%0h required=none", actual);
        end else begin
            checkOutput("status", 32'(actual), 32'(exp_status.pop_front()));
        end
    endtask

    // Monitor: a draw event is a rising request or a new target_sel; a status
    // event is any change of result_valid.
    logic       prev_blank = 1'b0;
    logic       prev_target = 1'b0;
    logic       prev_valid = 1'b0;
    logic [1:0] prev_sel = 2'd0;

    always @(negedge clk) begin
        if (blank_req && !prev_blank) popDraw(8'h10);
        if (target_req && (!prev_target || (target_sel != prev_sel))) popDraw(8'h20 | {6'd0, target_sel});
        if (status[0] != prev_valid) popStatus(status);
        prev_blank  = blank_req;
        prev_target = target_req;
        prev_sel    = target_sel;
        prev_valid  = status[0];
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulseFrame();
        frame_start = 1'b1;
        cycles(1);
        frame_start = 1'b0;
    endtask

    task automatic frame(input int len);
        cycles(len - 1);
        pulseFrame();
    endtask

    task automatic pulseTrigger(input logic [2:0] cnt);
        target_count = cnt;
        trigger = 1'b1;
        cycles(1);
        trigger = 1'b0;
    endtask

    task automatic doAck();
        ack = 1'b1;
        cycles(1);
        ack = 1'b0;
        cycles(2);
    endtask

    // One shot: trigger, ARM frame, blank frame, then nFrames target frames.
    // hitIdx<0 means no sensor; hitOffset<0 puts the sensor on the frame_start.
    // retrigIdx selects a target frame that gets a stray trigger edge.
    task automatic applyStimulus(input logic [2:0] cnt, input int nFrames, input int hitIdx,
                                 input int hitOffset, input int retrigIdx);
        pulseTrigger(cnt);
        checkOutput("busy_after_trigger", 32'(status), 32'h0040);
        frame(FL);
        frame(FL);
        for (int i = 0; i < nFrames; i++) begin
            if (i == hitIdx && hitOffset >= 0) begin
                cycles(hitOffset);
                sensor = 1'b1;
                cycles(1);
                sensor = 1'b0;
                cycles(FL - hitOffset - 2);
                pulseFrame();
            end else if (i == hitIdx) begin
                cycles(FL - 1);
                sensor = 1'b1;
                frame_start = 1'b1;
                cycles(1);
                sensor = 1'b0;
                frame_start = 1'b0;
            end else if (i == retrigIdx) begin
                cycles(5);
                trigger = 1'b1;
                cycles(2);
                trigger = 1'b0;
                cycles(FL - 8);
                pulseFrame();
            end else begin
                frame(FL);
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        rst = 1'b1;
        frame_start = 1'b0;
        trigger = 1'b0;
        sensor = 1'b0;
        target_count = 3'd0;
        ack = 1'b0;
        cycles(3);
        checkOutput("reset_status", 32'(status), 32'h0);
        checkOutput("reset_reqs", 32'({blank_req, target_req, target_sel, busy}), 32'h0);
        rst = 1'b0;
        cycles(2);

        // Hit on target 1 of 3
        exp_draw.push_back(8'h10); exp_draw.push_back(8'h20); exp_draw.push_back(8'h21);
        exp_status.push_back(16'h0007); exp_status.push_back(16'h0006);
        applyStimulus(3'd3, 2, 1, 10, -1);
        checkOutput("hit_busy", 32'(busy), 32'h0);
        checkOutput("hit_status", 32'(status), 32'h0007);
        doAck();

        // Miss over 4 targets with a stray trigger edge mid-sequence
        exp_draw.push_back(8'h10);
        for (int i = 0; i < 4; i++) exp_draw.push_back(8'h20 + 8'(i));
        exp_status.push_back(16'h0001); exp_status.push_back(16'h0000);
        applyStimulus(3'd4, 4, -1, 0, 1);
        doAck();

        // Count 7 clamps to 4 target frames
        exp_draw.push_back(8'h10);
        for (int i = 0; i < 4; i++) exp_draw.push_back(8'h20 + 8'(i));
        exp_status.push_back(16'h0001); exp_status.push_back(16'h0000);
        applyStimulus(3'd7, 4, -1, 0, -1);
        doAck();

        // Sensor coincident with frame_start at the end of target 2
        exp_draw.push_back(8'h10); exp_draw.push_back(8'h20);
        exp_draw.push_back(8'h21); exp_draw.push_back(8'h22);
        exp_status.push_back(16'h000B); exp_status.push_back(16'h000A);
        applyStimulus(3'd4, 3, 2, -1, -1);
        doAck();

        // Cheat: sensor already high when the blank frame begins
        exp_draw.push_back(8'h10);
        exp_status.push_back(16'h0011); exp_status.push_back(16'h0010);
        sensor = 1'b1;
        pulseTrigger(3'd2);
        frame(FL);
        cycles(3);
        sensor = 1'b0;
        checkOutput("cheat_status", 32'(status), 32'h0011);
        doAck();

        // Timeout: frame_start stops after the ARM frame
        exp_draw.push_back(8'h10);
        exp_status.push_back(16'h0021); exp_status.push_back(16'h0020);
        pulseTrigger(3'd1);
        frame(FL);
        cycles(99);
        checkOutput("timeout_not_yet", 32'(status[0]), 32'h0);
        cycles(1);
        checkOutput("timeout_status", 32'(status), 32'h0021);
        doAck();

        // Count 0 goes straight to DONE; a trigger edge in DONE is ignored
        exp_status.push_back(16'h0001); exp_status.push_back(16'h0000);
        pulseTrigger(3'd0);
        cycles(2);
        checkOutput("zero_busy", 32'(busy), 32'h0);
        pulseTrigger(3'd3);
        cycles(3);
        checkOutput("zero_done_hold", 32'(status), 32'h0001);
        doAck();

        // Reset during target 1, trigger held high across reset release
        exp_draw.push_back(8'h10); exp_draw.push_back(8'h20); exp_draw.push_back(8'h21);
        pulseTrigger(3'd3);
        frame(FL);
        frame(FL);
        frame(FL);
        cycles(5);
        rst = 1'b1;
        trigger = 1'b1;
        cycles(1);
        checkOutput("rst_outputs", 32'({blank_req, target_req, target_sel, busy}), 32'h0);
        checkOutput("rst_status", 32'(status), 32'h0);
        cycles(1);
        rst = 1'b0;
        cycles(10);
        checkOutput("held_trigger_no_shot", 32'({busy, status}), 32'h0);
        trigger = 1'b0;
        cycles(5);

        checkOutput("draw_queue_drained", 32'(exp_draw.size()), 32'h0);
        checkOutput("status_queue_drained", 32'(exp_status.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
